// File: rtl/serial_pkg.sv
// Shared constants for the serial feeder / 10110 detector pair: FSM encoding
// and the default word width used by the feeder and the detector's bench.
package serial_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;

endpackage

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder: accepts WIDTH-bit words over valid/ready and
// streams them one bit per clock, reloading at the last bit so words abut.
module piso_bit_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_next_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             in_shift_s;
    logic             last_s;
    logic             xfer_s;

    // Advance the word one position toward the output end, zero-filling behind it.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign in_shift_s = (state_r == ST_SHIFT);
    assign last_s     = in_shift_s && (cnt_r == {CW{1'b0}});
    // Ready is state-only, so it can never form a loop with the sender's valid.
    assign din_ready  = (state_r == ST_IDLE) || last_s;
    assign xfer_s     = din_valid && din_ready;

    // Next-state, shift-register and counter logic.
    always_comb begin
        next_state_s = ST_IDLE;
        shreg_next_s = shreg_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    next_state_s = ST_SHIFT;
                    shreg_next_s = din;
                    cnt_next_s   = CW'(WIDTH - 1);
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != {CW{1'b0}}) begin
                    next_state_s = ST_SHIFT;
                    shreg_next_s = shift_out(shreg_r);
                    cnt_next_s   = cnt_r - CW'(1);
                end else if (xfer_s) begin
                    next_state_s = ST_SHIFT;
                    shreg_next_s = din;
                    cnt_next_s   = CW'(WIDTH - 1);
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                shreg_next_s = {WIDTH{1'b0}};
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= next_state_s;
            shreg_r <= shreg_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign sout       = in_shift_s ? (MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0]) : IDLE_BIT;
    assign sout_valid = in_shift_s;
    assign busy       = in_shift_s;
    assign frame_done = last_s;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Bench for piso_bit_feeder: an MSB-first and an LSB-first instance share the
// same stimulus; a queue scoreboard checks every cycle, plus table/sequence checks.
module tb_piso_bit_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic m_ready, m_sout, m_sv, m_busy, m_fd;
    logic l_ready, l_sout, l_sv, l_busy, l_fd;

    int checks = 0;
    int fails  = 0;

    bit q_msb[$];
    bit q_lsb[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .sout(m_sout), .sout_valid(m_sv),
        .busy(m_busy), .frame_done(m_fd)
    );

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .sout(l_sout), .sout_valid(l_sv),
        .busy(l_busy), .frame_done(l_fd)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void mon(string tag, int qs, bit head, bit idle,
                                logic so, logic sv, logic bz, logic fd, logic rdy);
        chk({tag, " sout"},       {31'd0, so},  {31'd0, (qs > 0) ? head : idle});
        chk({tag, " sout_valid"}, {31'd0, sv},  {31'd0, qs > 0});
        chk({tag, " busy"},       {31'd0, bz},  {31'd0, qs > 0});
        chk({tag, " frame_done"}, {31'd0, fd},  {31'd0, qs == 1});
        chk({tag, " din_ready"},  {31'd0, rdy}, {31'd0, qs <= 1});
    endfunction

    // Scoreboard push: a transfer happens when the model has no bits left pending.
    always @(posedge clk) begin
        if (rst_n && din_valid && q_msb.size() == 0) begin
            for (int i = 0; i < 8; i++) begin
                q_msb.push_back(din[7-i]);
                q_lsb.push_back(din[i]);
            end
        end
    end

    // Scoreboard check/pop on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon("msb", q_msb.size(), (q_msb.size() > 0) ? q_msb[0] : 1'b0, 1'b0,
            m_sout, m_sv, m_busy, m_fd, m_ready);
        mon("lsb", q_lsb.size(), (q_lsb.size() > 0) ? q_lsb[0] : 1'b0, 1'b1,
            l_sout, l_sv, l_busy, l_fd, l_ready);
        if (q_msb.size() > 0) void'(q_msb.pop_front());
        if (q_lsb.size() > 0) void'(q_lsb.pop_front());
    end

    task automatic send_one(input vec_t v);
        logic [7:0] sm;
        logic [7:0] sl;
        sm = 8'h00;
        sl = 8'h00;
        @(posedge clk); #1;
        din = v.din;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sm = {sm[6:0], m_sout};
            sl = {sl[6:0], l_sout};
        end
        chk("table msb stream", {24'd0, sm}, {24'd0, v.exp_msb});
        chk("table lsb stream", {24'd0, sl}, {24'd0, v.exp_lsb});
        repeat (2) @(posedge clk);
    endtask

    task automatic stream_two(input logic [7:0] w0, input logic [15:0] exp_m,
                              input logic [15:0] exp_l, input bit perturb, string nm);
        logic [15:0] sm;
        logic [15:0] sl;
        sm = 16'h0000;
        sl = 16'h0000;
        @(posedge clk); #1;
        din = w0;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din = perturb ? 8'hAA : exp_m[7:0];
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sm = {sm[14:0], m_sout};
            sl = {sl[14:0], l_sout};
            chk({nm, " no bubble"}, {31'd0, m_sv & l_sv}, 32'd1);
            if (perturb && i == 2) din_valid = 1'b0;
            if (perturb && i == 4) begin
                din = 8'hFF;
                din_valid = 1'b1;
            end
            if (i == 8) din_valid = 1'b0;
        end
        chk({nm, " msb stream"}, {16'd0, sm}, {16'd0, exp_m});
        chk({nm, " lsb stream"}, {16'd0, sl}, {16'd0, exp_l});
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{din: 8'hB0, exp_msb: 8'hB0, exp_lsb: 8'h0D};
        vecs[1] = '{din: 8'h0D, exp_msb: 8'h0D, exp_lsb: 8'hB0};
        vecs[2] = '{din: 8'hB6, exp_msb: 8'hB6, exp_lsb: 8'h6D};
        vecs[3] = '{din: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
        vecs[4] = '{din: 8'h12, exp_msb: 8'h12, exp_lsb: 8'h48};
        vecs[5] = '{din: 8'hC4, exp_msb: 8'hC4, exp_lsb: 8'h23};

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("reset m_sout",   {31'd0, m_sout},  32'd0);
        chk("reset l_sout",   {31'd0, l_sout},  32'd1);
        chk("reset sv",       {31'd0, m_sv},    32'd0);
        chk("reset busy",     {31'd0, m_busy},  32'd0);
        chk("reset fd",       {31'd0, m_fd},    32'd0);
        chk("reset ready",    {31'd0, m_ready}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            send_one(vecs[k]);
        end

        stream_two(8'hB6, 16'hB6D0, 16'h6D0B, 1'b0, "b2b");
        stream_two(8'h3C, 16'h3CFF, 16'h3CFF, 1'b1, "bp");

        // Reset in the middle of a word
        @(posedge clk); #1;
        din = 8'hB6;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        q_msb.delete();
        q_lsb.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst m_sout", {31'd0, m_sout},  32'd0);
        chk("midrst l_sout", {31'd0, l_sout},  32'd1);
        chk("midrst sv",     {31'd0, m_sv | l_sv}, 32'd0);
        chk("midrst busy",   {31'd0, m_busy},  32'd0);
        chk("midrst ready",  {31'd0, m_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post-reset quiet", {31'd0, m_sv | l_sv}, 32'd0);
        end
        send_one(vecs[0]);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
